mul8_seq: RTL and testbench

MUL8_SEQ -- requirements
Module: mul8_seq

---
 rtl/mul8_seq_if.sv | 13 +
 rtl/mul8_seq.sv | 149 ++++++++++++++
 tb/tb_mul8_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mul8_seq_if.sv
// mul8_seq_if: operand/handshake/result bundle for the sequential 8x8 multiplier.
// The master drives operands and start; the slave returns busy, done and the product.
interface mul8_seq_if;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] m;

  modport master (output x, output y, output start, input busy, input done, input m);
  modport slave  (input x, input y, input start, output busy, output done, output m);
endinterface

// File: rtl/mul8_seq.sv
// mul8_seq: sequential 8x8 unsigned multiplier built from one shared 4x4
// multiplier and a 16-bit accumulator. One nibble partial product is added
// per cycle (S0..S3), followed by a one-cycle DONE state.
// Optional build macro MUL8_SEQ_ZERO_SKIP_EN: when defined, a zero operand at
// acceptance jumps straight from IDLE to DONE with a zero product.
module mul8_seq (
  input  logic      clock,
  input  logic      reset,
  mul8_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    DONE = 3'd5
  } state_t;

  // The single shared 4x4 multiplier; the product of two nibbles fits in 8 bits.
  function automatic logic [7:0] mul4(input logic [3:0] a, input logic [3:0] b);
    mul4 = {4'd0, a} * {4'd0, b};
  endfunction

  state_t      state_r, state_s;
  logic [7:0]  x_r, x_s;
  logic [7:0]  y_r, y_s;
  logic [15:0] acc_r, acc_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic [3:0]  a_s, b_s;
  logic [3:0]  sh_s;
  logic [7:0]  pp_s;
  logic [15:0] sum_s;

  // Pick the nibble pair and weight for the current step and form acc + partial product.
  always_comb begin
    a_s  = 4'd0;
    b_s  = 4'd0;
    sh_s = 4'd0;
    case (state_r)
      S0: begin
        a_s  = x_r[3:0];
        b_s  = y_r[3:0];
        sh_s = 4'd0;
      end
      S1: begin
        a_s  = x_r[3:0];
        b_s  = y_r[7:4];
        sh_s = 4'd4;
      end
      S2: begin
        a_s  = x_r[7:4];
        b_s  = y_r[3:0];
        sh_s = 4'd4;
      end
      S3: begin
        a_s  = x_r[7:4];
        b_s  = y_r[7:4];
        sh_s = 4'd8;
      end
      default: begin
        a_s  = 4'd0;
        b_s  = 4'd0;
        sh_s = 4'd0;
      end
    endcase
    pp_s  = mul4(a_s, b_s);
    // The full product never exceeds 16 bits, so any carry out is simply dropped.
    sum_s = acc_r + ({8'd0, pp_s} << sh_s);
  end

  // Next-state, operand capture and accumulator update; outputs are derived from the next state.
  always_comb begin
    state_s = state_r;
    x_s     = x_r;
    y_s     = y_r;
    acc_s   = acc_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          x_s   = bus.x;
          y_s   = bus.y;
          acc_s = 16'd0;
`ifdef MUL8_SEQ_ZERO_SKIP_EN
          if ((bus.x == 8'd0) || (bus.y == 8'd0)) begin
            state_s = DONE;
          end else begin
            state_s = S0;
          end
`else
          state_s = S0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      S0: begin
        acc_s   = sum_s;
        state_s = S1;
      end
      S1: begin
        acc_s   = sum_s;
        state_s = S2;
      end
      S2: begin
        acc_s   = sum_s;
        state_s = S3;
      end
      S3: begin
        acc_s   = sum_s;
        state_s = DONE;
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
    done_s = (state_s == DONE);
  end

  // State, operand, accumulator and registered status flags; reset aborts any operation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      x_r     <= 8'd0;
      y_r     <= 8'd0;
      acc_r   <= 16'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      x_r     <= x_s;
      y_r     <= y_s;
      acc_r   <= acc_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.m    = acc_r;

endmodule

// File: tb/tb_mul8_seq.sv
// tb_mul8_seq: directed, table-driven bench for mul8_seq plus hand-written
// sequences for ignored start, mid-operation reset and back-to-back starts.
module tb_mul8_seq;

  logic clock;
  logic reset;

  mul8_seq_if bus ();

  mul8_seq dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] m;
  } vec_t;

  vec_t vecs [10];
  int   n_checks;
  int   n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] x, input logic [7:0] y);
`ifdef MUL8_SEQ_ZERO_SKIP_EN
    if ((x == 8'd0) || (y == 8'd0)) return 1;
`endif
    return 5;
  endfunction

  // One start pulse, operands scrambled after acceptance; checks latency,
  // busy duration, product, single done pulse and held result.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] m_exp);
    int lat;
    int bcnt;
    logic [15:0] m_seen;
    lat    = 0;
    bcnt   = 0;
    m_seen = 16'd0;
    @(negedge clock);
    bus.x     = x;
    bus.y     = y;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    bus.x     = 8'($urandom);
    bus.y     = 8'($urandom);
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clock);
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat    = k;
        m_seen = bus.m;
        break;
      end
    end
    check($sformatf("latency %h*%h", x, y), lat, exp_lat(x, y));
    check($sformatf("busy cycles %h*%h", x, y), bcnt, exp_lat(x, y));
    check($sformatf("product %h*%h", x, y), {16'd0, m_seen}, {16'd0, m_exp});
    @(negedge clock);
    check("done single pulse", {31'd0, bus.done}, 32'd0);
    check("busy low after done", {31'd0, bus.busy}, 32'd0);
    check("m held after done", {16'd0, bus.m}, {16'd0, m_exp});
  endtask

  initial begin
    int   dcnt;
    int   first_k;
    int   second_k;
    logic [15:0] m1;
    logic [15:0] m2;

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{x: 8'h12, y: 8'h34, m: 16'h03A8};
    vecs[1] = '{x: 8'hFF, y: 8'hFF, m: 16'hFE01};
    vecs[2] = '{x: 8'hA5, y: 8'h3C, m: 16'h26AC};
    vecs[3] = '{x: 8'h00, y: 8'h5A, m: 16'h0000};
    vecs[4] = '{x: 8'h01, y: 8'hFF, m: 16'h00FF};
    vecs[5] = '{x: 8'h80, y: 8'h02, m: 16'h0100};
    vecs[6] = '{x: 8'hFF, y: 8'h00, m: 16'h0000};
    vecs[7] = '{x: 8'hF0, y: 8'h0F, m: 16'h0E10};
    vecs[8] = '{x: 8'hAB, y: 8'hCD, m: 16'h88EF};
    vecs[9] = '{x: 8'h07, y: 8'h09, m: 16'h003F};

    reset     = 1'b1;
    bus.x     = 8'h00;
    bus.y     = 8'h00;
    bus.start = 1'b0;
    #1;
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset m", {16'd0, bus.m}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].m);
    end

    // Start pulsed during S1 with new operands must be ignored.
    dcnt = 0;
    m1   = 16'd0;
    @(negedge clock);
    bus.x     = 8'h10;
    bus.y     = 8'h10;
    bus.start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (k == 1) bus.start = 1'b0;
      if (k == 2) begin
        bus.x     = 8'h02;
        bus.y     = 8'h03;
        bus.start = 1'b1;
      end
      if (k == 3) bus.start = 1'b0;
      if (bus.done) begin
        dcnt++;
        m1 = bus.m;
      end
    end
    check("ignored start: done pulses", dcnt, 32'd1);
    check("ignored start: product", {16'd0, m1}, 32'h0000_0100);

    // Reset asserted in S2 aborts the operation with no done pulse.
    dcnt = 0;
    @(negedge clock);
    bus.x     = 8'h55;
    bus.y     = 8'h66;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort done", {31'd0, bus.done}, 32'd0);
    check("abort m", {16'd0, bus.m}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (bus.done || bus.busy) dcnt++;
    end
    check("abort: no activity after reset", dcnt, 32'd0);
    run_op(8'h07, 8'h09, 16'h003F);

    // Start held high for 12 cycles: two operations, done pulses 6 cycles apart.
    dcnt     = 0;
    first_k  = 0;
    second_k = 0;
    m1       = 16'd0;
    m2       = 16'd0;
    @(negedge clock);
    bus.x     = 8'h0F;
    bus.y     = 8'h11;
    bus.start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (bus.done) begin
        dcnt++;
        if (dcnt == 1) begin
          first_k = k;
          m1      = bus.m;
        end else begin
          second_k = k;
          m2       = bus.m;
        end
      end
    end
    bus.start = 1'b0;
    check("held start: done pulses", dcnt, 32'd2);
    check("held start: pulse spacing", second_k - first_k, 32'd6);
    check("held start: first product", {16'd0, m1}, 32'h0000_00FF);
    check("held start: second product", {16'd0, m2}, 32'h0000_00FF);
    for (int k = 0; k < 8; k++) @(negedge clock);
    check("held start: idle afterwards", {31'd0, bus.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
